sync_fifo: RTL and testbench
============================

SYNC_FIFO -- requirements
Module: sync_fifo

Interface
REQ-001 SHALL have parameter DATA_WIDTH, default 8, meaning word width in bits.
REQ-002 SHALL have parameter ADDR_WIDTH, default 9, meaning depth = 2**ADDR_WIDTH words.
REQ-003 SHALL have parameter OUTPUT_REG, default "FALSE", meaning "TRUE" adds one rdata pipeline register.
REQ-004 SHALL have parameter AFULL_THRESH, default 2**ADDR_WIDTH-4, meaning almost_full asserts when level >= value.
REQ-005 SHALL have parameter AEMPTY_THRESH, default 4, meaning almost_empty asserts when level <= value.
REQ-006 SHALL have port clock, input, 1, meaning the single clock; all logic on its rising edge.
REQ-007 SHALL have port reset, input, 1, meaning synchronous active-high reset.
REQ-008 SHALL have port wdata, input, DATA_WIDTH, meaning write data.
REQ-009 SHALL have port we, input, 1, meaning write request.
REQ-010 SHALL have port re, input, 1, meaning read request.
REQ-011 SHALL have port rdata, output, DATA_WIDTH, meaning read data.
REQ-012 SHALL have port rvalid, output, 1, meaning rdata holds a word popped by an accepted read.
REQ-013 SHALL have ports full, empty, almost_full and almost_empty, each output, 1, meaning status flags.
REQ-014 SHALL have ports overflow and underflow, each output, 1, meaning sticky error flags.
REQ-015 SHALL have port level, output, ADDR_WIDTH+1, meaning stored word count, present only with SYNC_FIFO_LEVEL_EN.

Function
REQ-016 SHALL accept a write when we=1 and (full=0 or an accepted read occurs in the same cycle).
REQ-017 SHALL accept a read when re=1 and empty=0.
REQ-018 SHALL set overflow when we=1, full=1 and re=0, dropping the write with no change to memory or pointers.
REQ-019 SHALL set underflow when re=1 and empty=1, with no pointer change.
REQ-020 SHALL keep overflow and underflow set until reset.
REQ-021 SHALL keep ADDR_WIDTH-bit read and write pointers that wrap modulo 2**ADDR_WIDTH.
REQ-022 SHALL keep an ADDR_WIDTH+1-bit level counter: +1 on write only, -1 on read only, unchanged on both or neither.
REQ-023 SHALL derive full (level == 2**ADDR_WIDTH), empty (level == 0), almost_full and almost_empty as registered flags updated in the same cycle as level.
REQ-024 SHALL, on simultaneous write and read when empty, accept the write, flag underflow and leave empty=0 on the next cycle.
REQ-025 SHALL present read data 1 cycle after an accepted read with OUTPUT_REG="FALSE", or 2 cycles after with "TRUE", with rvalid pulsing high in that same cycle.
REQ-026 SHALL hold rdata stable between accepted reads.
REQ-027 SHALL preserve word order across pointer wrap-around.

Reset
REQ-028 SHALL, on reset, clear both pointers, level, overflow, underflow, rvalid and rdata, and set empty=1, full=0, almost_empty=1 and almost_full=0.
REQ-029 SHALL, on reset asserted mid-operation, discard in-flight reads (no rvalid) and ignore we and re in that cycle.
REQ-030 SHALL NOT clear memory contents on reset.

Configuration
REQ-031 SHALL, with macro SYNC_FIFO_LEVEL_EN defined, expose the level port driven by the internal counter.
REQ-032 SHALL, without SYNC_FIFO_LEVEL_EN, omit the level port while keeping the internal counter and all flags functionally identical.

Structure
REQ-033 SHALL take OUTPUT_REG string constants and the default threshold helper functions from shared package sync_fifo_pkg.
REQ-034 SHALL implement storage by instantiating simple_dual_port_ram with wclk and rclk tied to clock, re tied to the accepted read and OUTPUT_REG passed through.

Verification
REQ-035 SHALL verify: reset, then write 70,72,...(+2) for 8 cycles, then read 8 -> rdata sequence 70..84, rvalid per latency, empty=1 at end.
REQ-036 SHALL verify: fill 512 words (ADDR_WIDTH=9) -> full=1 and almost_full=1 from level 508; a 513th write -> overflow=1 and level stays 512.
REQ-037 SHALL verify: read while empty -> underflow=1, no rvalid, level 0.
REQ-038 SHALL verify: when full, we=1 and re=1 in the same cycle -> both accepted, level stays 512, no overflow.
REQ-039 SHALL verify: stream 3x512 words with continuous write and read -> data in order across wrap, no errors, for both OUTPUT_REG settings.
REQ-040 SHALL verify: reset asserted with 5 words stored and a read in flight -> next cycle empty=1, rvalid=0, overflow=0, underflow=0.

Source files
------------

// File: rtl/sync_fifo_pkg.sv
// sync_fifo_pkg: constants and helper functions shared by sync_fifo and its
// storage. Holds the OUTPUT_REG string values and the default almost-full /
// almost-empty thresholds, so every user of the FIFO agrees on them.
package sync_fifo_pkg;

    // Legal values of the OUTPUT_REG parameter.
    localparam string OUTPUT_REG_TRUE  = "TRUE";
    localparam string OUTPUT_REG_FALSE = "FALSE";

    // almost_full fires this many words before the FIFO is completely full.
    localparam int AFULL_MARGIN = 4;

    // almost_empty fires at or below this many stored words.
    localparam int AEMPTY_DEFAULT = 4;

    // Default almost_full threshold: depth minus the margin.
    function automatic int default_afull_thresh(input int addr_width);
        return (1 << addr_width) - AFULL_MARGIN;
    endfunction

    // Default almost_empty threshold, independent of depth.
    function automatic int default_aempty_thresh();
        return AEMPTY_DEFAULT;
    endfunction

endpackage

// File: rtl/sync_fifo_ram.sv
// simple_dual_port_ram: one write port, one read port, 2**ADDR_WIDTH words.
// The read port is registered; OUTPUT_REG = "TRUE" adds a second output
// register. Only the read-side output registers are reset: the memory array
// itself keeps its contents across reset.
module simple_dual_port_ram
    import sync_fifo_pkg::*;
#(
    parameter int    DATA_WIDTH = 8,
    parameter int    ADDR_WIDTH = 9,
    parameter string OUTPUT_REG = OUTPUT_REG_FALSE
) (
    input  logic                  wclk,
    input  logic                  we,
    input  logic [ADDR_WIDTH-1:0] waddr,
    input  logic [DATA_WIDTH-1:0] wdata,
    input  logic                  rclk,
    input  logic                  rrst,
    input  logic                  re,
    input  logic [ADDR_WIDTH-1:0] raddr,
    output logic [DATA_WIDTH-1:0] rdata
);

    localparam int DEPTH = 1 << ADDR_WIDTH;

    logic [DATA_WIDTH-1:0] mem [DEPTH];
    logic [DATA_WIDTH-1:0] rd_q;

    // Write port: store wdata at waddr; no reset so contents survive it.
    always_ff @(posedge wclk) begin
        if (we) begin
            mem[waddr] <= wdata;
        end
    end

    // Read stage 1: capture the addressed word only on a read, so the output
    // holds its value between reads. A same-cycle write to raddr returns the
    // old word, which is what a FIFO reading its oldest entry needs.
    always_ff @(posedge rclk) begin
        if (rrst) begin
            rd_q <= '0;
        end else if (re) begin
            rd_q <= mem[raddr];
        end
    end

    generate
        if (OUTPUT_REG == OUTPUT_REG_TRUE) begin : g_oreg
            logic [DATA_WIDTH-1:0] rd_pipe_q;

            // Read stage 2: free-running copy of stage 1. Stage 1 only moves
            // on a read, so this stage also stays stable between reads.
            always_ff @(posedge rclk) begin
                if (rrst) begin
                    rd_pipe_q <= '0;
                end else begin
                    rd_pipe_q <= rd_q;
                end
            end

            assign rdata = rd_pipe_q;
        end else begin : g_noreg
            assign rdata = rd_q;
        end
    endgenerate

endmodule

// File: rtl/sync_fifo.sv
// sync_fifo: single-clock FIFO of 2**ADDR_WIDTH words of DATA_WIDTH bits.
// Optional build macro SYNC_FIFO_LEVEL_EN exposes the stored-word counter on
// the 'level' port; without it the port is absent and the counter remains
// internal, with identical flag behaviour.
//
// Handshake: a write is taken when we=1 and the FIFO is not full, or when a
// read is accepted in the same cycle. A read is taken when re=1 and the FIFO
// is not empty. The data of an accepted read appears on rdata 1 cycle later
// (2 with OUTPUT_REG="TRUE"), and rvalid is high for exactly that cycle.
// A write refused because the FIFO is full and nothing is read sets the
// sticky overflow flag. A read of an empty FIFO sets the sticky underflow flag.
// Both flags clear only on reset.
module sync_fifo
    import sync_fifo_pkg::*;
#(
    parameter int    DATA_WIDTH    = 8,
    parameter int    ADDR_WIDTH    = 9,
    parameter string OUTPUT_REG    = OUTPUT_REG_FALSE,
    parameter int    AFULL_THRESH  = default_afull_thresh(ADDR_WIDTH),
    parameter int    AEMPTY_THRESH = default_aempty_thresh()
) (
    input  logic                  clock,
    input  logic                  reset,
    input  logic [DATA_WIDTH-1:0] wdata,
    input  logic                  we,
    input  logic                  re,
    output logic [DATA_WIDTH-1:0] rdata,
    output logic                  rvalid,
    output logic                  full,
    output logic                  empty,
    output logic                  almost_full,
    output logic                  almost_empty,
    output logic                  overflow,
    output logic                  underflow
`ifdef SYNC_FIFO_LEVEL_EN
    ,
    output logic [ADDR_WIDTH:0]   level
`endif
);

    localparam logic [ADDR_WIDTH:0] DEPTH_LVL  = (ADDR_WIDTH+1)'(1) << ADDR_WIDTH;
    localparam logic [ADDR_WIDTH:0] AFULL_LVL  = (ADDR_WIDTH+1)'(AFULL_THRESH);
    localparam logic [ADDR_WIDTH:0] AEMPTY_LVL = (ADDR_WIDTH+1)'(AEMPTY_THRESH);
    localparam bit                  OREG_EN    = (OUTPUT_REG == OUTPUT_REG_TRUE);

    logic [ADDR_WIDTH-1:0] wptr_q;
    logic [ADDR_WIDTH-1:0] rptr_q;
    logic [ADDR_WIDTH:0]   level_q;
    logic [ADDR_WIDTH:0]   level_nxt;
    logic                  rd_ok;
    logic                  wr_ok;
    logic                  rvalid_s1_q;

    // Accepted read and write. Reset masks both, so we/re are ignored in a
    // reset cycle and the memory is not written during it.
    always_comb begin
        rd_ok = re & ~empty & ~reset;
        wr_ok = we & (~full | rd_ok) & ~reset;
    end

    // Next stored-word count: up on write only, down on read only.
    always_comb begin
        level_nxt = level_q;
        case ({wr_ok, rd_ok})
            2'b10:   level_nxt = level_q + 1'b1;
            2'b01:   level_nxt = level_q - 1'b1;
            default: level_nxt = level_q;
        endcase
    end

    // Pointers and level counter; pointers wrap naturally at 2**ADDR_WIDTH.
    always_ff @(posedge clock) begin
        if (reset) begin
            wptr_q  <= '0;
            rptr_q  <= '0;
            level_q <= '0;
        end else begin
            if (wr_ok) begin
                wptr_q <= wptr_q + 1'b1;
            end
            if (rd_ok) begin
                rptr_q <= rptr_q + 1'b1;
            end
            level_q <= level_nxt;
        end
    end

    // Status flags, registered from the next level so they move with level.
    always_ff @(posedge clock) begin
        if (reset) begin
            full         <= 1'b0;
            empty        <= 1'b1;
            almost_full  <= 1'b0;
            almost_empty <= 1'b1;
        end else begin
            full         <= (level_nxt == DEPTH_LVL);
            empty        <= (level_nxt == '0);
            almost_full  <= (level_nxt >= AFULL_LVL);
            almost_empty <= (level_nxt <= AEMPTY_LVL);
        end
    end

    // Sticky error flags. A write while full with a read in the same cycle is
    // legal and does not count as overflow.
    always_ff @(posedge clock) begin
        if (reset) begin
            overflow  <= 1'b0;
            underflow <= 1'b0;
        end else begin
            if (we && full && !re) begin
                overflow <= 1'b1;
            end
            if (re && empty) begin
                underflow <= 1'b1;
            end
        end
    end

    // First stage of the read-valid pipeline; reset drops reads in flight.
    always_ff @(posedge clock) begin
        if (reset) begin
            rvalid_s1_q <= 1'b0;
        end else begin
            rvalid_s1_q <= rd_ok;
        end
    end

    generate
        if (OREG_EN) begin : g_rvalid_oreg
            logic rvalid_s2_q;

            // Second valid stage, lined up with the RAM output register.
            always_ff @(posedge clock) begin
                if (reset) begin
                    rvalid_s2_q <= 1'b0;
                end else begin
                    rvalid_s2_q <= rvalid_s1_q;
                end
            end

            assign rvalid = rvalid_s2_q;
        end else begin : g_rvalid_noreg
            assign rvalid = rvalid_s1_q;
        end
    endgenerate

`ifdef SYNC_FIFO_LEVEL_EN
    assign level = level_q;
`endif

    simple_dual_port_ram #(
        .DATA_WIDTH (DATA_WIDTH),
        .ADDR_WIDTH (ADDR_WIDTH),
        .OUTPUT_REG (OUTPUT_REG)
    ) u_ram (
        .wclk  (clock),
        .we    (wr_ok),
        .waddr (wptr_q),
        .wdata (wdata),
        .rclk  (clock),
        .rrst  (reset),
        .re    (rd_ok),
        .raddr (rptr_q),
        .rdata (rdata)
    );

endmodule

// File: tb/tb_sync_fifo.sv
// tb_sync_fifo: drives two sync_fifo instances (OUTPUT_REG "FALSE" and
// "TRUE") with the same directed stimulus, compares both against a queue
// model every cycle, and pins the model with hand-computed expectations.
module tb_sync_fifo;

    localparam int DW    = 8;
    localparam int AW    = 9;
    localparam int DEPTH = 1 << AW;

    logic          clk = 1'b0;
    logic          reset = 1'b1;
    logic [DW-1:0] wdata = '0;
    logic          we = 1'b0;
    logic          re = 1'b0;

    logic [DW-1:0] rdata_a, rdata_b;
    logic          rvalid_a, rvalid_b;
    logic          full_a, full_b, empty_a, empty_b;
    logic          af_a, af_b, ae_a, ae_b;
    logic          ovf_a, ovf_b, udf_a, udf_b;
`ifdef SYNC_FIFO_LEVEL_EN
    logic [AW:0]   level_a, level_b;
`endif

    int n_checks = 0;
    int n_err    = 0;
    bit check_en = 1'b0;

    // ---------------- clock ----------------
    always #5 clk = ~clk;

    // ---------------- DUTs ----------------
    sync_fifo #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW), .OUTPUT_REG("FALSE")) dut_a (
        .clock(clk), .reset(reset), .wdata(wdata), .we(we), .re(re),
        .rdata(rdata_a), .rvalid(rvalid_a), .full(full_a), .empty(empty_a),
        .almost_full(af_a), .almost_empty(ae_a),
        .overflow(ovf_a), .underflow(udf_a)
`ifdef SYNC_FIFO_LEVEL_EN
        , .level(level_a)
`endif
    );

    sync_fifo #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW), .OUTPUT_REG("TRUE")) dut_b (
        .clock(clk), .reset(reset), .wdata(wdata), .we(we), .re(re),
        .rdata(rdata_b), .rvalid(rvalid_b), .full(full_b), .empty(empty_b),
        .almost_full(af_b), .almost_empty(ae_b),
        .overflow(ovf_b), .underflow(udf_b)
`ifdef SYNC_FIFO_LEVEL_EN
        , .level(level_b)
`endif
    );

    // ---------------- checker ----------------
    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // ---------------- behavioural model ----------------
    logic [DW-1:0] mq[$];
    bit            m_ovf, m_udf;
    bit            pend1_v, pend2_v;
    logic [DW-1:0] pend1_d, pend2_d;
    bit            m_rvalid_a, m_rvalid_b;
    logic [DW-1:0] m_rdata_a, m_rdata_b;

    always @(posedge clk) begin
        bit            rd_ok;
        bit            wr_ok;
        logic [DW-1:0] popped;
        if (reset) begin
            mq.delete();
            m_ovf = 0; m_udf = 0;
            pend1_v = 0; pend2_v = 0; pend1_d = '0; pend2_d = '0;
            m_rvalid_a = 0; m_rvalid_b = 0;
            m_rdata_a = '0; m_rdata_b = '0;
        end else begin
            rd_ok = re && (mq.size() > 0);
            wr_ok = we && ((mq.size() < DEPTH) || rd_ok);
            if (we && mq.size() == DEPTH && !re) m_ovf = 1;
            if (re && mq.size() == 0) m_udf = 1;
            popped = '0;
            if (rd_ok) popped = mq.pop_front();
            if (wr_ok) mq.push_back(wdata);
            // popped words age by one cycle per clock; output at 1 or 2 cycles
            pend2_v = pend1_v; pend2_d = pend1_d;
            pend1_v = rd_ok;   pend1_d = popped;
            m_rvalid_a = pend1_v;
            if (pend1_v) m_rdata_a = pend1_d;
            m_rvalid_b = pend2_v;
            if (pend2_v) m_rdata_b = pend2_d;
        end
    end

    // Per-cycle compare of every output of both instances against the model.
    always @(negedge clk) begin
        if (check_en) begin
            chk("a_rvalid", 32'(rvalid_a), 32'(m_rvalid_a));
            chk("a_rdata",  32'(rdata_a),  32'(m_rdata_a));
            chk("b_rvalid", 32'(rvalid_b), 32'(m_rvalid_b));
            chk("b_rdata",  32'(rdata_b),  32'(m_rdata_b));
            chk("a_full",   32'(full_a),   32'(mq.size() == DEPTH));
            chk("b_full",   32'(full_b),   32'(mq.size() == DEPTH));
            chk("a_empty",  32'(empty_a),  32'(mq.size() == 0));
            chk("b_empty",  32'(empty_b),  32'(mq.size() == 0));
            chk("a_afull",  32'(af_a),     32'(mq.size() >= DEPTH - 4));
            chk("b_afull",  32'(af_b),     32'(mq.size() >= DEPTH - 4));
            chk("a_aempty", 32'(ae_a),     32'(mq.size() <= 4));
            chk("b_aempty", 32'(ae_b),     32'(mq.size() <= 4));
            chk("a_ovf",    32'(ovf_a),    32'(m_ovf));
            chk("b_ovf",    32'(ovf_b),    32'(m_ovf));
            chk("a_udf",    32'(udf_a),    32'(m_udf));
            chk("b_udf",    32'(udf_b),    32'(m_udf));
`ifdef SYNC_FIFO_LEVEL_EN
            chk("a_level",  32'(level_a),  32'(mq.size()));
            chk("b_level",  32'(level_b),  32'(mq.size()));
`endif
        end
    end

    // Collected read data per instance, for the ordered-sequence checks.
    logic [DW-1:0] got_a[$];
    logic [DW-1:0] got_b[$];

    always @(negedge clk) begin
        if (rvalid_a) got_a.push_back(rdata_a);
        if (rvalid_b) got_b.push_back(rdata_b);
    end

    // ---------------- driver tasks ----------------
    task automatic cyc(input logic w, input logic r, input logic [DW-1:0] d);
        we = w; re = r; wdata = d;
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        reset = 1'b1; we = 1'b0; re = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        reset = 1'b0;
    endtask

    // ---------------- directed sequence ----------------
    initial begin
        int bad_a;
        int bad_b;

        // reset state
        do_reset();
        check_en = 1'b1;
        chk("rst_empty_a", 32'(empty_a), 1); chk("rst_empty_b", 32'(empty_b), 1);
        chk("rst_full_a",  32'(full_a),  0); chk("rst_ae_a",    32'(ae_a),    1);
        chk("rst_af_a",    32'(af_a),    0); chk("rst_rvalid_b", 32'(rvalid_b), 0);
        chk("rst_rdata_a", 32'(rdata_a), 0); chk("rst_rdata_b", 32'(rdata_b), 0);
        chk("rst_ovf_a",   32'(ovf_a),   0); chk("rst_udf_b",   32'(udf_b),   0);

        // write 70,72,..,84 then read 8
        got_a.delete(); got_b.delete();
        for (int i = 0; i < 8; i++) cyc(1'b1, 1'b0, 8'(70 + 2 * i));
        chk("t1_ae_after8", 32'(ae_a), 0);
        cyc(1'b0, 1'b1, '0);
        chk("t1_lat_a_valid", 32'(rvalid_a), 1);
        chk("t1_lat_a_data",  32'(rdata_a),  70);
        chk("t1_lat_b_valid", 32'(rvalid_b), 0);
        cyc(1'b0, 1'b1, '0);
        chk("t1_lat_b_valid2", 32'(rvalid_b), 1);
        chk("t1_lat_b_data",   32'(rdata_b),  70);
        for (int i = 0; i < 6; i++) cyc(1'b0, 1'b1, '0);
        repeat (3) cyc(1'b0, 1'b0, '0);
        chk("t1_count_a", 32'(got_a.size()), 8);
        chk("t1_count_b", 32'(got_b.size()), 8);
        for (int i = 0; i < 8; i++) begin
            if (i < got_a.size()) chk("t1_seq_a", 32'(got_a[i]), 32'(70 + 2 * i));
            if (i < got_b.size()) chk("t1_seq_b", 32'(got_b[i]), 32'(70 + 2 * i));
        end
        chk("t1_end_empty_a", 32'(empty_a), 1);
        chk("t1_end_empty_b", 32'(empty_b), 1);
        chk("t1_hold_a", 32'(rdata_a), 84);

        // read while empty -> underflow, no rvalid
        cyc(1'b0, 1'b1, '0);
        chk("t2_udf_a", 32'(udf_a), 1); chk("t2_udf_b", 32'(udf_b), 1);
        chk("t2_rvalid_a", 32'(rvalid_a), 0);
        cyc(1'b0, 1'b0, '0);
        chk("t2_rvalid_b", 32'(rvalid_b), 0);
        chk("t2_empty_a", 32'(empty_a), 1);
        do_reset();

        // fill to full, then write+read while full, then overflow
        for (int i = 0; i < DEPTH; i++) begin
            cyc(1'b1, 1'b0, 8'(i));
            if (i == 506) chk("t3_af_507", 32'(af_a), 0);
            if (i == 507) chk("t3_af_508", 32'(af_a), 1);
        end
        chk("t3_full_a", 32'(full_a), 1); chk("t3_full_b", 32'(full_b), 1);
        chk("t3_af_b", 32'(af_b), 1);
        cyc(1'b1, 1'b1, 8'hAA);
        chk("t4_full_rw", 32'(full_a), 1);
        chk("t4_rvalid_a", 32'(rvalid_a), 1);
        chk("t4_rdata_a", 32'(rdata_a), 0);
        chk("t4_no_ovf_a", 32'(ovf_a), 0); chk("t4_no_ovf_b", 32'(ovf_b), 0);
        cyc(1'b1, 1'b0, 8'hBB);
        chk("t3_ovf_a", 32'(ovf_a), 1); chk("t3_ovf_b", 32'(ovf_b), 1);
        chk("t3_still_full", 32'(full_a), 1);
`ifdef SYNC_FIFO_LEVEL_EN
        chk("t3_level_a", 32'(level_a), 512);
`endif
        cyc(1'b0, 1'b0, '0);
        do_reset();

        // simultaneous write and read while empty
        cyc(1'b1, 1'b1, 8'h5A);
        chk("t5_udf_a", 32'(udf_a), 1);
        chk("t5_empty_a", 32'(empty_a), 0); chk("t5_empty_b", 32'(empty_b), 0);
        cyc(1'b0, 1'b1, '0);
        cyc(1'b0, 1'b0, '0);
        chk("t5_data_a", 32'(rdata_a), 32'h5A);
        chk("t5_data_b", 32'(rdata_b), 32'h5A);
        do_reset();

        // stream 3x512 words with continuous write and read
        got_a.delete(); got_b.delete();
        cyc(1'b1, 1'b0, 8'd0);
        for (int i = 1; i <= 3 * DEPTH; i++) cyc(1'b1, 1'b1, 8'(i));
        cyc(1'b0, 1'b1, '0);
        repeat (3) cyc(1'b0, 1'b0, '0);
        chk("t6_count_a", 32'(got_a.size()), 32'(3 * DEPTH + 1));
        chk("t6_count_b", 32'(got_b.size()), 32'(3 * DEPTH + 1));
        bad_a = 0; bad_b = 0;
        for (int i = 0; i < got_a.size(); i++) if (got_a[i] !== 8'(i)) bad_a++;
        for (int i = 0; i < got_b.size(); i++) if (got_b[i] !== 8'(i)) bad_b++;
        chk("t6_order_a", 32'(bad_a), 0);
        chk("t6_order_b", 32'(bad_b), 0);
        chk("t6_ovf_a", 32'(ovf_a), 0); chk("t6_udf_a", 32'(udf_a), 0);
        chk("t6_ovf_b", 32'(ovf_b), 0); chk("t6_udf_b", 32'(udf_b), 0);
        chk("t6_empty_b", 32'(empty_b), 1);

        // reset with 5 words stored and a read in flight
        for (int i = 0; i < 5; i++) cyc(1'b1, 1'b0, 8'(8'h11 + i));
        cyc(1'b0, 1'b1, '0);
        reset = 1'b1; we = 1'b1; re = 1'b1;
        @(posedge clk);
        #1;
        chk("t7_empty_a", 32'(empty_a), 1); chk("t7_empty_b", 32'(empty_b), 1);
        chk("t7_rvalid_a", 32'(rvalid_a), 0); chk("t7_rvalid_b", 32'(rvalid_b), 0);
        chk("t7_ovf_a", 32'(ovf_a), 0); chk("t7_udf_a", 32'(udf_a), 0);
        chk("t7_ovf_b", 32'(ovf_b), 0); chk("t7_udf_b", 32'(udf_b), 0);
        reset = 1'b0;
        cyc(1'b0, 1'b0, '0);
        chk("t7_rvalid_b_late", 32'(rvalid_b), 0);
        chk("t7_rdata_b", 32'(rdata_b), 0);
        cyc(1'b0, 1'b0, '0);

        $display("Result: errors=%0d of %0d checks", n_err, n_checks);
        $finish;
    end

endmodule
